// File: rtl/all_things_button.sv
// rtl/all_things_button.sv - Debounced button/switch input port with W1C edge capture and maskable irq
module all_things_button #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_prev_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rd_q, rd_d;

  logic [WIDTH-1:0] rise, fall, evt, clr;
  logic             wr_en;
  logic             unused_wdata;

  // Upper write-data bits only exist for bus width; fold them into a dummy sink.
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // A level is accepted only after the synchronised input differs from deb for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement resets the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;
  assign fall = ~deb_q & deb_prev_q;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      evt = rise;
    end else if (EDGE_TYPE == 1) begin
      evt = fall;
    end else begin
      evt = rise | fall;
    end
  end

  // New events take priority over a clear landing in the same cycle.
  always_comb begin
    clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr) | evt;
    mask_d    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d = 32'(deb_q);
      2'd2:    rd_d = 32'(mask_q);
      2'd3:    rd_d = 32'(edgecap_q);
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= RESET_VALUE;
      sync2_q    <= RESET_VALUE;
      deb_q      <= RESET_VALUE;
      deb_prev_q <= RESET_VALUE;
      edgecap_q  <= '0;
      mask_q     <= '0;
      rd_q       <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      edgecap_q  <= edgecap_d;
      mask_q     <= mask_d;
      rd_q       <= rd_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = rd_q;
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_all_things_button.sv
// tb/tb_all_things_button.sv - Directed-vector bench for all_things_button (falling-edge and any-edge instances)
module tb_all_things_button;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata, readdata_any;
  logic        irq, irq_any;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  all_things_button #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  all_things_button #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(4'hF)
  ) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_any),
    .in_port(in_port), .irq(irq_any)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset and no spurious edge afterwards
    repeat (3) tick();
    check_eq("reset_rd", readdata, 32'h0);
    check_eq("reset_irq", irq, 1'b0);
    check_eq("reset_rd_any", readdata_any, 32'h0);
    check_eq("reset_irq_any", irq_any, 1'b0);
    reset = 1'b0;
    address = 2'd0;
    tick();
    check_eq("post_reset_data", readdata, 32'hF);
    address = 2'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("no_spurious_edge", readdata, 32'h0);
    end

    // Debounce accept on bit 0 (falling): deb changes at edge 6, readdata at edge 7
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'hE;
    repeat (6) tick();
    check_eq("deb_not_yet", readdata, 32'hF);
    check_eq("irq_not_yet", irq, 1'b0);
    tick();
    check_eq("deb_accepted", readdata, 32'hE);
    check_eq("irq_after_fall", irq, 1'b1);
    check_eq("irq_any_after_fall", irq_any, 1'b1);
    address = 2'd3;
    tick();
    check_eq("edgecap_fall", readdata, 32'h1);
    check_eq("edgecap_fall_any", readdata_any, 32'h1);

    // W1C clear
    bus_write(2'd3, 32'h1);
    check_eq("irq_cleared", irq, 1'b0);
    check_eq("irq_any_cleared", irq_any, 1'b0);
    address = 2'd3;
    tick();
    check_eq("edgecap_cleared", readdata, 32'h0);

    // Glitch of 3 cycles on bit 1 must be rejected
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (10) tick();
    check_eq("glitch_edgecap", readdata, 32'h0);
    check_eq("glitch_irq", irq, 1'b0);
    address = 2'd0;
    tick();
    check_eq("glitch_deb", readdata, 32'hE);

    // Release bit 0: rise ignored by falling instance, captured by any-edge instance
    in_port = 4'hF;
    repeat (8) tick();
    address = 2'd3;
    tick();
    check_eq("rise_ignored", readdata, 32'h0);
    check_eq("rise_any", readdata_any, 32'h1);

    // Press again with clear landing on the capture edge: set wins
    in_port = 4'hE;
    repeat (6) tick();
    bus_write(2'd3, 32'h1);
    check_eq("set_wins_irq", irq, 1'b1);
    check_eq("set_wins_irq_any", irq_any, 1'b1);
    address = 2'd3;
    tick();
    check_eq("set_wins_edgecap", readdata, 32'h1);
    check_eq("set_wins_edgecap_any", readdata_any, 32'h1);

    // Mask gating on bit 2
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
    in_port = 4'hA;
    repeat (8) tick();
    address = 2'd3;
    tick();
    check_eq("mask_edgecap", readdata, 32'h4);
    check_eq("mask_edgecap_any", readdata_any, 32'h4);
    check_eq("masked_irq", irq, 1'b0);
    bus_write(2'd2, 32'h4);
    check_eq("unmasked_irq", irq, 1'b1);
    check_eq("unmasked_irq_any", irq_any, 1'b1);
    address = 2'd1;
    tick();
    check_eq("reserved_addr", readdata, 32'h0);
    address = 2'd2;
    tick();
    check_eq("mask_readback", readdata, 32'h4);
    bus_write(2'd2, 32'h0);
    check_eq("remasked_irq", irq, 1'b0);

    // Second capture of bit 2 (release) after a clear, any-edge only
    bus_write(2'd3, 32'hF);
    in_port = 4'hE;
    repeat (8) tick();
    address = 2'd3;
    tick();
    check_eq("release_ignored", readdata, 32'h0);
    check_eq("release_any", readdata_any, 32'h4);

    // Reset two cycles into a debounce window
    bus_write(2'd2, 32'hF);
    check_eq("pre_reset_irq_any", irq_any, 1'b1);
    in_port = 4'h6;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    check_eq("midreset_rd", readdata, 32'h0);
    check_eq("midreset_irq_any", irq_any, 1'b0);
    reset = 1'b0;
    address = 2'd0;
    repeat (6) tick();
    check_eq("restart_not_yet", readdata, 32'hF);
    tick();
    check_eq("restart_accepted", readdata, 32'h6);
    address = 2'd3;
    tick();
    check_eq("restart_edgecap", readdata, 32'h9);
    check_eq("restart_edgecap_any", readdata_any, 32'h9);
    check_eq("restart_irq", irq, 1'b0);
    address = 2'd2;
    tick();
    check_eq("mask_after_reset", readdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
